// File: rtl/multi_button_debouncer.sv
// N-channel pushbutton debouncer: 2-FF synchronizer, shared sample tick,
// consecutive-sample acceptance, and press/release/long-press pulses per channel.
module multi_button_debouncer #(
  parameter int CHANNELS       = 4,
  parameter int CLK_FREQ       = 50000000,
  parameter int SAMPLE_HZ      = 1000,
  parameter int STABLE_SAMPLES = 4,
  parameter int LONG_SAMPLES   = 1000,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse,
  output logic                tick
);

  localparam int DIV = CLK_FREQ / SAMPLE_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = (STABLE_SAMPLES > 0) ? $clog2(STABLE_SAMPLES + 1) : 1;
  localparam int HW  = (LONG_SAMPLES > 0) ? $clog2(LONG_SAMPLES + 1) : 1;
  localparam logic [CHANNELS-1:0] IDLE_RAW = {CHANNELS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    LP_IDLE    = 2'd0,
    LP_PRESSED = 2'd1,
    LP_HELD    = 2'd2
  } lp_state_t;

  logic [DW-1:0]       r_div;
  logic                w_tick;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] w_sample;
  logic [CHANNELS-1:0] w_flip;
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_press;
  logic [CHANNELS-1:0] r_release;
  logic [CHANNELS-1:0] r_long;
  logic [SW-1:0]       r_cnt   [CHANNELS];
  logic [HW-1:0]       r_hold  [CHANNELS];
  // Long-press state per channel; kept as a named array so checkers can bind to it.
  lp_state_t           r_lp_state [CHANNELS];

  assign w_tick = (r_div == DW'(DIV - 1));
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // Synchronizers reset to the idle raw level so leaving reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= IDLE_RAW;
      r_sync2 <= IDLE_RAW;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2 ^ IDLE_RAW;

  always_comb begin
    w_flip = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_flip[i] = w_tick && (w_sample[i] != r_level[i]) &&
                  ((r_cnt[i] + SW'(1)) == SW'(STABLE_SAMPLES));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i]      <= '0;
        r_hold[i]     <= '0;
        r_lp_state[i] <= LP_IDLE;
      end
    end else begin
      r_press   <= w_flip & ~r_level;
      r_release <= w_flip & r_level;
      r_level   <= r_level ^ w_flip;
      r_long    <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_tick) begin
          if ((w_sample[i] == r_level[i]) || w_flip[i]) begin
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + SW'(1);
          end
          // A release on this tick wins over reaching the long-press count.
          case (r_lp_state[i])
            LP_IDLE: begin
              if (w_flip[i]) begin
                r_lp_state[i] <= LP_PRESSED;
                r_hold[i]     <= '0;
              end
            end
            LP_PRESSED: begin
              if (w_flip[i]) begin
                r_lp_state[i] <= LP_IDLE;
                r_hold[i]     <= '0;
              end else if ((r_hold[i] + HW'(1)) == HW'(LONG_SAMPLES)) begin
                r_lp_state[i] <= LP_HELD;
                r_hold[i]     <= HW'(LONG_SAMPLES);
                r_long[i]     <= 1'b1;
              end else begin
                r_hold[i] <= r_hold[i] + HW'(1);
              end
            end
            LP_HELD: begin
              if (w_flip[i]) begin
                r_lp_state[i] <= LP_IDLE;
                r_hold[i]     <= '0;
              end
            end
            default: begin
              r_lp_state[i] <= LP_IDLE;
              r_hold[i]     <= '0;
            end
          endcase
        end
      end
    end
  end

  assign level         = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: an active-high and an active-low instance
// driven by directed and random stimulus, checked against a sample-history model.
module tb_multi_button_debouncer;

  localparam int CH        = 4;
  localparam int CLK_FREQ  = 100;
  localparam int SAMPLE_HZ = 10;
  localparam int DIV       = CLK_FREQ / SAMPLE_HZ;
  localparam int STABLE    = 3;
  localparam int LONG      = 5;
  localparam int HSZ       = 1024;
  // Expected entry: {cycle stamp[43:12], press[11:8], release[7:4], long[3:0]}
  localparam int W         = 44;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH-1:0] btn_hi, btn_lo;
  logic [CH-1:0] lvl_hi, prs_hi, rel_hi, lng_hi;
  logic [CH-1:0] lvl_lo, prs_lo, rel_lo, lng_lo;
  logic          tick_hi, tick_lo;

  multi_button_debouncer #(
    .CHANNELS(CH), .CLK_FREQ(CLK_FREQ), .SAMPLE_HZ(SAMPLE_HZ),
    .STABLE_SAMPLES(STABLE), .LONG_SAMPLES(LONG), .ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .clk(clk), .rst(rst), .btn_in(btn_hi), .level(lvl_hi),
    .press_pulse(prs_hi), .release_pulse(rel_hi), .long_pulse(lng_hi), .tick(tick_hi)
  );

  multi_button_debouncer #(
    .CHANNELS(CH), .CLK_FREQ(CLK_FREQ), .SAMPLE_HZ(SAMPLE_HZ),
    .STABLE_SAMPLES(STABLE), .LONG_SAMPLES(LONG), .ACTIVE_LOW(1'b1)
  ) u_dut_lo (
    .clk(clk), .rst(rst), .btn_in(btn_lo), .level(lvl_lo),
    .press_pulse(prs_lo), .release_pulse(rel_lo), .long_pulse(lng_lo), .tick(tick_lo)
  );

  // ---------------- reference model ----------------
  int            g_cyc = 0;
  int            m_since = 0;
  int            m_n = 0;
  logic          m_tick = 1'b0;
  logic [CH-1:0] m_hist [2][2];
  logic [CH-1:0] m_lvl  [2];
  logic          m_smp  [2][CH][HSZ];
  int            m_flip_at  [2][CH];
  int            m_press_at [2][CH];
  logic [W-1:0]  exp_q_hi[$];
  logic [W-1:0]  exp_q_lo[$];

  initial begin
    logic [CH-1:0] s, p, r, l, inact;
    bit accept;
    m_lvl[0] = '0;
    m_lvl[1] = '0;
    forever begin
      @(posedge clk);
      g_cyc++;
      if (rst) begin
        m_since = 0;
        m_n     = 0;
        for (int d = 0; d < 2; d++) begin
          inact        = (d == 1) ? '1 : '0;
          m_lvl[d]     = '0;
          m_hist[d][0] = inact;
          m_hist[d][1] = inact;
          for (int c = 0; c < CH; c++) begin
            m_flip_at[d][c]  = 0;
            m_press_at[d][c] = 0;
          end
        end
      end else begin
        if (((m_since + 1) % DIV) == 0) begin
          m_n++;
          for (int d = 0; d < 2; d++) begin
            s = m_hist[d][1] ^ ((d == 1) ? '1 : '0);
            p = '0; r = '0; l = '0;
            for (int c = 0; c < CH; c++) begin
              m_smp[d][c][m_n % HSZ] = s[c];
              // accept when the last STABLE samples, all taken since the previous
              // acceptance, disagree with the current level
              accept = ((m_n - m_flip_at[d][c]) >= STABLE);
              for (int k = 0; k < STABLE; k++)
                if (m_smp[d][c][(m_n - k) % HSZ] == m_lvl[d][c]) accept = 0;
              if (accept) begin
                m_flip_at[d][c] = m_n;
                if (m_lvl[d][c] == 1'b0) begin
                  p[c] = 1'b1;
                  m_press_at[d][c] = m_n;
                end else begin
                  r[c] = 1'b1;
                end
                m_lvl[d][c] = ~m_lvl[d][c];
              end else if (m_lvl[d][c] && (m_n - m_press_at[d][c]) == LONG) begin
                l[c] = 1'b1;
              end
            end
            if ((p | r | l) != '0) begin
              if (d == 0) exp_q_hi.push_back({32'(g_cyc), p, r, l});
              else        exp_q_lo.push_back({32'(g_cyc), p, r, l});
            end
          end
        end
        m_hist[0][1] = m_hist[0][0];
        m_hist[0][0] = btn_hi;
        m_hist[1][1] = m_hist[1][0];
        m_hist[1][0] = btn_lo;
        m_since++;
      end
      m_tick = (((m_since + 1) % DIV) == 0);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int n_pass  = 0;
  int n_total = 0;
  bit mon_en  = 0;
  bit done    = 0;
  bit mon_done = 0;

  task automatic check_val(input string name, input int d,
                           input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, d, g_cyc, act, exp);
  endtask

  task automatic check_dut(input int d, input logic tk, input logic [CH-1:0] lv,
                           input logic [CH-1:0] p, input logic [CH-1:0] r,
                           input logic [CH-1:0] l);
    logic [W-1:0] e;
    bit has;
    check_val("tick", d, W'(tk), W'(m_tick));
    check_val("level", d, W'(lv), W'(m_lvl[d]));
    has = 0;
    e   = '0;
    if (d == 0) begin
      if (exp_q_hi.size() > 0) begin
        e = exp_q_hi[0];
        if (e[W-1:12] == 32'(g_cyc)) begin
          e = exp_q_hi.pop_front();
          has = 1;
        end
      end
    end else begin
      if (exp_q_lo.size() > 0) begin
        e = exp_q_lo[0];
        if (e[W-1:12] == 32'(g_cyc)) begin
          e = exp_q_lo.pop_front();
          has = 1;
        end
      end
    end
    if (has) check_val("pulses", d, W'({p, r, l}), W'(e[11:0]));
    else if ((p | r | l) != '0) check_val("unexpected_pulse", d, W'({p, r, l}), '0);
  endtask

  initial begin
    logic [W-1:0] e;
    wait (mon_en);
    while (!done) begin
      @(posedge clk);
      #1;
      check_dut(0, tick_hi, lvl_hi, prs_hi, rel_hi, lng_hi);
      check_dut(1, tick_lo, lvl_lo, prs_lo, rel_lo, lng_lo);
    end
    while (exp_q_hi.size() > 0) begin
      e = exp_q_hi.pop_front();
      check_val("missing_pulse", 0, '0, e);
    end
    while (exp_q_lo.size() > 0) begin
      e = exp_q_lo.pop_front();
      check_val("missing_pulse", 1, '0, e);
    end
    mon_done = 1;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_model_level(input int d, input int c, input logic v);
    for (int k = 0; k < 200; k++) begin
      if (m_lvl[d][c] == v) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    btn_hi = '0;
    btn_lo = '1;
    wait_clks(3);
    rst    = 1'b0;
    mon_en = 1;

    // idle after reset: ticks only
    wait_clks(30);

    // clean press and release on channel 0
    btn_hi[0] = 1'b1;  wait_clks(40);
    btn_hi[0] = 1'b0;  wait_clks(40);

    // channel 1 bouncing faster than the acceptance window, then a real press
    for (int k = 0; k < 200; k += 7) begin
      btn_hi[1] = ~btn_hi[1];
      wait_clks(7);
    end
    btn_hi[1] = 1'b1;  wait_clks(40);
    btn_hi[1] = 1'b0;  wait_clks(40);

    // long press on channel 2
    btn_hi[2] = 1'b1;  wait_clks(100);
    btn_hi[2] = 1'b0;  wait_clks(40);

    // release landing on the long-press tick, then one tick later
    for (int v = 0; v < 2; v++) begin
      btn_hi[3] = 1'b1;
      wait_model_level(0, 3, 1'b1);
      wait_clks((v == 0) ? 20 : 30);
      btn_hi[3] = 1'b0;
      wait_clks(50);
    end

    // all channels together, then reset while pressed
    btn_hi = '1;  wait_clks(40);
    rst = 1'b1;  btn_hi = '0;  wait_clks(2);
    rst = 1'b0;  wait_clks(40);

    // active-low instance
    btn_lo[0] = 1'b0;  wait_clks(40);
    btn_lo[0] = 1'b1;  wait_clks(40);

    // random bouncing, holds and occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      btn_hi = btn_hi ^ CH'($urandom_range(0, 15));
      btn_lo = btn_lo ^ CH'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) rst = 1'b1;
      wait_clks($urandom_range(1, 45));
      rst = 1'b0;
    end
    btn_hi = '0;
    btn_lo = '1;
    wait_clks(60);

    done = 1;
    wait (mon_done);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
